// File: rtl/mips_muldiv_if.sv
// Bundle of signals between the core and the multiply/divide unit.
//   start   : operation request, sampled while busy is low
//   op      : operation select (MULT, MULTU, DIV, DIVU, MTHI, MTLO)
//   a, b    : rs / rt operands
//   busy    : unit occupied, core stalls MF/MT/mul/div
//   done    : one-cycle pulse, hi/lo updated
//   divzero : qualified by done, last divide had a zero divisor
//   hi, lo  : architectural HI/LO registers
// master = core side, slave = unit side.
interface mips_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             divzero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, divzero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, divzero, hi, lo
    );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers.
// Multiply is shift-add, divide is restoring, one bit per cycle on magnitudes;
// signs are applied in a final fix-up cycle.
//   clk   : clock, rising edge
//   reset : asynchronous active-high, clears all state
//   bus   : mips_muldiv_if slave (start/op/a/b in, busy/done/divzero/hi/lo out)
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mips_muldiv_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    state_e             state;
    logic [CW-1:0]      cnt;
    // Multiply: {partial product, remaining multiplier}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   m;        // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_res;  // negate product / quotient
    logic               neg_rem;  // remainder follows dividend sign
    logic               dz;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               busy_r, done_r, dz_r;

    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.divzero = dz_r;

    logic               sgn_op, sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     madd, shl, diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;

    always_comb begin
        sgn_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        sa     = sgn_op & bus.a[WIDTH-1];
        sb     = sgn_op & bus.b[WIDTH-1];
        mag_a  = sa ? -bus.a : bus.a;
        mag_b  = sb ? -bus.b : bus.b;

        // Carry out of the add lands in the top bit and shifts down with the product.
        madd     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
        mul_next = {madd, acc[WIDTH-1:1]};

        shl      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = shl - {1'b0, m};
        div_next = diff[WIDTH] ? {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        prod_fix = neg_res ? -acc : acc;
        q_fix    = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix    = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            m       <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                acc     <= {{WIDTH{1'b0}}, mag_b};
                                m       <= mag_a;
                                is_div  <= 1'b0;
                                neg_res <= sa ^ sb;
                                neg_rem <= 1'b0;
                                dz      <= 1'b0;
                                cnt     <= CW'(WIDTH - 1);
                                busy_r  <= 1'b1;
                                state   <= CALC;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc     <= {{WIDTH{1'b0}}, mag_a};
                                m       <= mag_b;
                                is_div  <= 1'b1;
                                neg_res <= sa ^ sb;
                                neg_rem <= sa;
                                dz      <= (bus.b == '0);
                                cnt     <= CW'(WIDTH - 1);
                                busy_r  <= 1'b1;
                                state   <= CALC;
                            end
                            OP_MTHI: hi_r <= bus.a;
                            OP_MTLO: lo_r <= bus.a;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    if (cnt == '0)
                        state <= FIX;
                    else
                        cnt <= cnt - 1'b1;
                end
                FIX: begin
                    if (!is_div) begin
                        {hi_r, lo_r} <= prod_fix;
                    end else if (!dz) begin
                        lo_r <= q_fix;
                        hi_r <= r_fix;
                    end
                    dz_r   <= is_div & dz;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_muldiv.sv
module tb_mips_muldiv;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mips_muldiv_if #(.WIDTH(32)) bus ();
    mips_muldiv #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_hi, m_lo;
    logic        m_dz;

    function automatic void model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, q, r;
        m_dz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
            3'd2: if (b == 0) m_dz = 1'b1;
                  else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
            3'd3: if (b == 0) m_dz = 1'b1;
                  else begin m_lo = a / b; m_hi = a % b; end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endfunction

    // Issue one mul/div op and collect what the DUT shows; no judging here.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic busy_ok, output logic busy_at_done,
                          output logic [31:0] ohi, output logic [31:0] olo,
                          output logic odz, output logic done_after);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
        busy_ok = bus.busy;
        cyc = 0;
        for (int i = 0; i < 60 && !bus.done; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (!bus.done && !bus.busy) busy_ok = 1'b0;
        end
        busy_at_done = bus.busy;
        ohi = bus.hi; olo = bus.lo; odz = bus.divzero;
        @(posedge clk); #1;
        done_after = bus.done;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.divzero !== 1'b0) begin errors++; $display("FAIL reset_divzero got=%b exp=0", bus.divzero); end
        checks++; if (bus.hi !== 32'h0)     begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        checks++; if (bus.lo !== 32'h0)     begin errors++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        @(negedge clk); reset = 1'b0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
    endtask

    logic [2:0]  d_op [7] = '{3'd1, 3'd0, 3'd0, 3'd2, 3'd3, 3'd2, 3'd3};
    logic [31:0] d_a  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd5};
    logic [31:0] d_b  [7] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0};
    logic [31:0] e_hi [7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h0};
    logic [31:0] e_lo [7] = '{32'h00000001, 32'hFFFFFFEB, 32'h0, 32'hFFFFFFFD, 32'h0000000E, 32'h80000000, 32'h80000000};
    logic        e_dz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic test_directed();
        int cyc; logic bok, bdn, dz, da; logic [31:0] h, l;
        for (int i = 0; i < 7; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], cyc, bok, bdn, h, l, dz, da);
            checks++; if (cyc !== 33) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=33", i, cyc); end
            checks++; if (bok !== 1'b1 || bdn !== 1'b0) begin errors++; $display("FAIL dir%0d_busy ok=%b at_done=%b exp ok=1 at_done=0", i, bok, bdn); end
            checks++; if (h !== e_hi[i]) begin errors++; $display("FAIL dir%0d_hi got=%h exp=%h", i, h, e_hi[i]); end
            checks++; if (l !== e_lo[i]) begin errors++; $display("FAIL dir%0d_lo got=%h exp=%h", i, l, e_lo[i]); end
            checks++; if (dz !== e_dz[i]) begin errors++; $display("FAIL dir%0d_divzero got=%b exp=%b", i, dz, e_dz[i]); end
            checks++; if (da !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, da); end
        end
        m_hi = e_hi[6]; m_lo = e_lo[6];
    endtask

    task automatic test_mt();
        @(negedge clk); bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h12345678;
        @(posedge clk); #1; bus.start = 1'b0;
        model_op(3'd4, 32'h12345678, 32'h0);
        checks++; if (bus.hi !== m_hi) begin errors++; $display("FAIL mthi_hi got=%h exp=%h", bus.hi, m_hi); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mthi_nobusy busy=%b done=%b exp 0/0", bus.busy, bus.done); end
        @(negedge clk); bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'hCAFEF00D;
        @(posedge clk); #1; bus.start = 1'b0;
        model_op(3'd5, 32'hCAFEF00D, 32'h0);
        checks++; if (bus.lo !== m_lo) begin errors++; $display("FAIL mtlo_lo got=%h exp=%h", bus.lo, m_lo); end
        for (int k = 6; k < 8; k++) begin
            @(negedge clk); bus.start = 1'b1; bus.op = 3'(k); bus.a = 32'hDEADBEEF; bus.b = 32'h3;
            @(posedge clk); #1; bus.start = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
                errors++;
                $display("FAIL op%0d_ignored busy=%b done=%b hi=%h lo=%h exp 0 0 %h %h", k, bus.busy, bus.done, bus.hi, bus.lo, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        @(negedge clk); bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd6; bus.b = 32'd7;
        @(posedge clk); #1;
        model_op(3'd1, 32'd6, 32'd7);
        cyc = 0;
        bus.op = 3'd5; bus.a = 32'h55555555;
        repeat (3) begin @(posedge clk); #1; cyc++; end
        bus.op = 3'd0; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
        repeat (3) begin @(posedge clk); #1; cyc++; end
        bus.start = 1'b0;
        for (int i = 0; i < 60 && !bus.done; i++) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc !== 33) begin errors++; $display("FAIL ignore_latency got=%0d exp=33", cyc); end
        checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin errors++; $display("FAIL ignore_result got=%h_%h exp=%h_%h", bus.hi, bus.lo, m_hi, m_lo); end
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_no_restart busy=%b exp=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk); bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'h0001_0003; bus.b = 32'h0002_0005;
        @(posedge clk); #1; bus.start = 1'b0;
        model_op(3'd1, 32'h0001_0003, 32'h0002_0005);
        for (int i = 0; i < 60 && !bus.done; i++) @(posedge clk) #1;
        checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin errors++; $display("FAIL b2b_first got=%h_%h exp=%h_%h", bus.hi, bus.lo, m_hi, m_lo); end
        // New request raised in the done cycle itself.
        bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd1000; bus.b = 32'd33;
        @(posedge clk); #1; bus.start = 1'b0;
        model_op(3'd3, 32'd1000, 32'd33);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b exp=1", bus.busy); end
        cyc = 0;
        for (int i = 0; i < 60 && !bus.done; i++) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_latency got=%0d exp=33", cyc); end
        checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin errors++; $display("FAIL b2b_second got=%h_%h exp=%h_%h", bus.hi, bus.lo, m_hi, m_lo); end
    endtask

    task automatic test_reset_mid();
        int cyc; logic bok, bdn, dz, da; logic [31:0] h, l;
        @(negedge clk); bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'hFFFF0000; bus.b = 32'h1234ABCD;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1; reset = 1'b1; #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            errors++;
            $display("FAIL midreset busy=%b done=%b hi=%h lo=%h exp all 0", bus.busy, bus.done, bus.hi, bus.lo);
        end
        @(negedge clk); reset = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'h0) begin errors++; $display("FAIL midreset_no_write busy=%b hi=%h exp 0 0", bus.busy, bus.hi); end
        run_op(3'd3, 32'd9, 32'd4, cyc, bok, bdn, h, l, dz, da);
        model_op(3'd3, 32'd9, 32'd4);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL postreset_latency got=%0d exp=33", cyc); end
        checks++; if (h !== m_hi || l !== m_lo) begin errors++; $display("FAIL postreset_divu got=%h_%h exp=%h_%h", h, l, m_hi, m_lo); end
    endtask

    task automatic test_random();
        int cyc; logic bok, bdn, dz, da; logic [31:0] h, l, a, b; logic [2:0] op;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                default: ;
            endcase
            run_op(op, a, b, cyc, bok, bdn, h, l, dz, da);
            model_op(op, a, b);
            checks++; if (cyc !== 33) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=33", n, cyc); end
            checks++; if (bok !== 1'b1 || bdn !== 1'b0) begin errors++; $display("FAIL rnd%0d_busy ok=%b at_done=%b exp 1 0", n, bok, bdn); end
            checks++; if (h !== m_hi) begin errors++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h exp=%h", n, op, a, b, h, m_hi); end
            checks++; if (l !== m_lo) begin errors++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h exp=%h", n, op, a, b, l, m_lo); end
            checks++; if (dz !== m_dz) begin errors++; $display("FAIL rnd%0d_divzero got=%b exp=%b", n, dz, m_dz); end
            checks++; if (da !== 1'b0) begin errors++; $display("FAIL rnd%0d_done_pulse got=%b exp=0", n, da); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_mt();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
